// File: rtl/jtsdram_arb.sv
// rtl/jtsdram_arb.sv - four-requester round-robin read arbiter in front of an SDRAM controller
module jtsdram_arb #(
  parameter int TOUT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_rd,
  input  logic [21:0] ch0_addr,
  output logic        ch0_ack,
  output logic        ch0_rdy,
  input  logic        ch1_rd,
  input  logic [21:0] ch1_addr,
  output logic        ch1_ack,
  output logic        ch1_rdy,
  input  logic        ch2_rd,
  input  logic [21:0] ch2_addr,
  output logic        ch2_ack,
  output logic        ch2_rdy,
  input  logic        ch3_rd,
  input  logic [21:0] ch3_addr,
  output logic        ch3_ack,
  output logic        ch3_rdy,
  output logic        sd_rd,
  output logic [21:0] sd_addr,
  output logic [1:0]  sd_ba,
  input  logic        sd_ack,
  input  logic        sd_rdy,
  input  logic        refresh_req,
  output logic        refresh_ok,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [TOUT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [TOUT_W-1:0] cnt_q, cnt_d;
  logic              sd_rd_q, sd_rd_d;
  logic [21:0]       sd_addr_q, sd_addr_d;
  logic [1:0]        sd_ba_q, sd_ba_d;
  logic [3:0]        ack_q, ack_d;
  logic [3:0]        rdy_q, rdy_d;
  logic              timeout_q, timeout_d;

  logic [3:0]        req;
  logic [1:0]        cand;
  logic [1:0]        winner;
  logic              found;
  logic [21:0]       addr_mux;
  logic [TOUT_W-1:0] cnt_inc;
  logic              tout_hit;

  assign req = {ch3_rd, ch2_rd, ch1_rd, ch0_rd};

  // Saturating increment; the transaction is abandoned on the edge the counter reaches its maximum.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign tout_hit = (cnt_inc == CNT_MAX);

  // Round-robin search starting just after the previous winner.
  always_comb begin
    cand   = '0;
    winner = last_q;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Address of the channel that wins this cycle's arbitration.
  always_comb begin
    addr_mux = ch0_addr;
    case (winner)
      2'd0: addr_mux = ch0_addr;
      2'd1: addr_mux = ch1_addr;
      2'd2: addr_mux = ch2_addr;
      2'd3: addr_mux = ch3_addr;
      default: addr_mux = ch0_addr;
    endcase
  end

  // Next-state logic: grant in IDLE, wait for the command accept in REQ, wait for data in WAIT.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    sd_rd_d   = sd_rd_q;
    sd_addr_d = sd_addr_q;
    sd_ba_d   = sd_ba_q;
    ack_d     = '0;
    rdy_d     = '0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        // Refresh window blocks new grants; stray sd_ack/sd_rdy are ignored here.
        if (!refresh_req && found) begin
          grant_d   = winner;
          sd_addr_d = addr_mux;
          sd_ba_d   = winner;
          sd_rd_d   = 1'b1;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (sd_ack) begin
          sd_rd_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          if (sd_rdy) begin
            rdy_d[grant_q] = 1'b1;
            last_d         = grant_q;
            state_d        = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (tout_hit) begin
          timeout_d = 1'b1;
          sd_rd_d   = 1'b0;
          last_d    = grant_q;
          state_d   = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (sd_rdy) begin
          rdy_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = IDLE;
        end else if (tout_hit) begin
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      sd_rd_q   <= 1'b0;
      sd_addr_q <= '0;
      sd_ba_q   <= 2'd0;
      ack_q     <= '0;
      rdy_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      sd_rd_q   <= sd_rd_d;
      sd_addr_q <= sd_addr_d;
      sd_ba_q   <= sd_ba_d;
      ack_q     <= ack_d;
      rdy_q     <= rdy_d;
      timeout_q <= timeout_d;
    end
  end

  assign ch0_ack    = ack_q[0];
  assign ch1_ack    = ack_q[1];
  assign ch2_ack    = ack_q[2];
  assign ch3_ack    = ack_q[3];
  assign ch0_rdy    = rdy_q[0];
  assign ch1_rdy    = rdy_q[1];
  assign ch2_rdy    = rdy_q[2];
  assign ch3_rdy    = rdy_q[3];
  assign sd_rd      = sd_rd_q;
  assign sd_addr    = sd_addr_q;
  assign sd_ba      = sd_ba_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);
  assign refresh_ok = (state_q == IDLE) & refresh_req;

endmodule

// File: tb/tb_jtsdram_arb.sv
// tb/tb_jtsdram_arb.sv - scoreboard bench for jtsdram_arb
module tb_jtsdram_arb;

  localparam int TW = 4;

  typedef struct packed {
    logic [1:0]  ch;
    logic [21:0] a;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd = '0;
  logic [21:0] addr [4];
  wire  [3:0]  ack;
  wire  [3:0]  rdy;
  wire         sd_rd;
  wire  [21:0] sd_addr;
  wire  [1:0]  sd_ba;
  logic        sd_ack = 1'b0;
  logic        sd_rdy = 1'b0;
  logic        refresh_req = 1'b0;
  wire         refresh_ok;
  wire         busy;
  wire         timeout;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int rdy_cnt = 0;
  logic prev_rd = 1'b0;
  logic [1:0] cur_ch = 2'd0;
  logic [1:0] last_m = 2'd3;
  sb_t exp_q [$];
  logic [1:0] grant_log [$];

  jtsdram_arb #(.TOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .ch0_rd(rd[0]), .ch0_addr(addr[0]), .ch0_ack(ack[0]), .ch0_rdy(rdy[0]),
    .ch1_rd(rd[1]), .ch1_addr(addr[1]), .ch1_ack(ack[1]), .ch1_rdy(rdy[1]),
    .ch2_rd(rd[2]), .ch2_addr(addr[2]), .ch2_ack(ack[2]), .ch2_rdy(rdy[2]),
    .ch3_rd(rd[3]), .ch3_addr(addr[3]), .ch3_ack(ack[3]), .ch3_rdy(rdy[3]),
    .sd_rd(sd_rd), .sd_addr(sd_addr), .sd_ba(sd_ba),
    .sd_ack(sd_ack), .sd_rdy(sd_rdy),
    .refresh_req(refresh_req), .refresh_ok(refresh_ok),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] c;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (mask[c]) rr_pick = c;
    end
  endfunction

  function automatic logic [1:0] expect_grant(input logic [3:0] mask);
    logic [1:0] w;
    w = rr_pick(last_m, mask);
    exp_q.push_back('{ch: w, a: addr[w]});
    return w;
  endfunction

  // Output monitor: pops the scoreboard on each new SDRAM command and checks pulse targets.
  always @(negedge clk) begin
    if (rst) begin
      prev_rd <= 1'b0;
    end else begin
      prev_rd <= sd_rd;
      if (sd_rd && !prev_rd) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_cmd", 32'(sd_ba), 32'hffff_ffff);
        end else begin
          check("sd_ba", 32'(sd_ba), 32'(exp_q[0].ch));
          check("sd_addr", 32'(sd_addr), 32'(exp_q[0].a));
          cur_ch <= exp_q[0].ch;
          grant_log.push_back(sd_ba);
          exp_q.delete(0);
        end
      end
      if (ack != 4'b0) begin
        check("ack_target", 32'(ack), 32'(4'b1 << cur_ch));
        ack_cnt <= ack_cnt + 1;
      end
      if (rdy != 4'b0) begin
        check("rdy_target", 32'(rdy), 32'(4'b1 << cur_ch));
        rdy_cnt <= rdy_cnt + 1;
      end
    end
  end

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!sd_rd && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sd_rd), 32'd1);
  endtask

  // Called at the negedge of the first REQ cycle; ends at the negedge where the rdy pulse is visible.
  task automatic respond(input int ack_dly, input int rdy_dly);
    for (int i = 0; i < ack_dly; i++) begin
      check("hold_sd_rd", 32'(sd_rd), 32'd1);
      @(negedge clk);
    end
    sd_ack = 1'b1;
    if (rdy_dly == 0) sd_rdy = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0;
    sd_rdy = 1'b0;
    check("sd_rd_drop", 32'(sd_rd), 32'd0);
    if (rdy_dly > 0) begin
      check("busy_wait", 32'(busy), 32'd1);
      repeat (rdy_dly - 1) @(negedge clk);
      sd_rdy = 1'b1;
      @(negedge clk);
      sd_rdy = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, n;
    logic [1:0] w;
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) addr[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_sd_ba", 32'(sd_ba), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request on ch2, dropped after grant
    a0 = ack_cnt; r0 = rdy_cnt;
    addr[2] = 22'h12345; rd[2] = 1'b1;
    w = expect_grant(4'b0100);
    @(negedge clk);
    check("t1_latency", 32'(sd_rd), 32'd1);
    rd[2] = 1'b0;
    respond(3, 5);
    check("t1_busy_low", 32'(busy), 32'd0);
    last_m = w;
    @(negedge clk);
    check("t1_acks", 32'(ack_cnt - a0), 32'd1);
    check("t1_rdys", 32'(rdy_cnt - r0), 32'd1);

    // Stray sd_ack/sd_rdy in IDLE
    a0 = ack_cnt; r0 = rdy_cnt;
    sd_ack = 1'b1; sd_rdy = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0; sd_rdy = 1'b0;
    @(negedge clk);
    check("idle_stray_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("idle_stray_acks", 32'(ack_cnt - a0), 32'd0);
    check("idle_stray_rdys", 32'(rdy_cnt - r0), 32'd0);

    // Refresh blocks grant, then same-cycle ack+rdy
    a0 = ack_cnt; r0 = rdy_cnt;
    refresh_req = 1'b1; addr[1] = 22'h2aaaa; rd[1] = 1'b1;
    @(negedge clk);
    check("ref_ok", 32'(refresh_ok), 32'd1);
    check("ref_sd_rd0", 32'(sd_rd), 32'd0);
    @(negedge clk);
    check("ref_sd_rd1", 32'(sd_rd), 32'd0);
    check("ref_busy", 32'(busy), 32'd0);
    refresh_req = 1'b0;
    w = expect_grant(4'b0010);
    @(negedge clk);
    check("ref_release_grant", 32'(sd_rd), 32'd1);
    rd[1] = 1'b0;
    respond(0, 0);
    check("same_cycle_idle", 32'(busy), 32'd0);
    last_m = w;
    @(negedge clk);
    check("same_cycle_acks", 32'(ack_cnt - a0), 32'd1);
    check("same_cycle_rdys", 32'(rdy_cnt - r0), 32'd1);

    // Round robin with all four requesting from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 2'd3;
    grant_log.delete();
    a0 = ack_cnt; r0 = rdy_cnt;
    for (int i = 0; i < 4; i++) addr[i] = 22'h100 * 22'(i + 1) + 22'h5;
    rd = 4'hf;
    for (int t = 0; t < 5; t++) begin
      w = expect_grant(4'hf);
      wait_rd("rr_grant");
      respond(1, 1);
      last_m = w;
    end
    rd = 4'h0;
    @(negedge clk);
    check("rr_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));
    check("rr_acks", 32'(ack_cnt - a0), 32'd5);
    check("rr_rdys", 32'(rdy_cnt - r0), 32'd5);

    // Timeout: sd_ack never arrives
    a0 = ack_cnt; r0 = rdy_cnt;
    addr[3] = 22'h3f00f; rd[3] = 1'b1;
    w = expect_grant(4'b1000);
    wait_rd("tout_grant");
    rd[3] = 1'b0;
    n = 0;
    while (sd_rd && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tout_req_cycles", 32'(n), 32'((1 << TW) - 1));
    check("tout_flag", 32'(timeout), 32'd1);
    check("tout_busy", 32'(busy), 32'd0);
    last_m = w;
    @(negedge clk);
    check("tout_acks", 32'(ack_cnt - a0), 32'd0);
    check("tout_rdys", 32'(rdy_cnt - r0), 32'd0);

    // Next request after timeout still served; flag stays set
    a0 = ack_cnt; r0 = rdy_cnt;
    addr[0] = 22'h00abc; rd[0] = 1'b1;
    w = expect_grant(4'b0001);
    wait_rd("post_tout_grant");
    rd[0] = 1'b0;
    respond(2, 2);
    last_m = w;
    @(negedge clk);
    check("post_tout_acks", 32'(ack_cnt - a0), 32'd1);
    check("post_tout_rdys", 32'(rdy_cnt - r0), 32'd1);
    check("tout_sticky", 32'(timeout), 32'd1);

    // Reset while in WAIT; late sd_rdy must be ignored
    a0 = ack_cnt; r0 = rdy_cnt;
    addr[1] = 22'h15555; rd[1] = 1'b1;
    w = expect_grant(4'b0010);
    wait_rd("wrst_grant");
    rd[1] = 1'b0;
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0;
    check("wrst_in_wait", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wrst_sd_rd", 32'(sd_rd), 32'd0);
    check("wrst_sd_addr", 32'(sd_addr), 32'd0);
    check("wrst_sd_ba", 32'(sd_ba), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_ack", 32'(ack), 32'd0);
    check("wrst_rdy", 32'(rdy), 32'd0);
    check("wrst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sd_rdy = 1'b1;
    @(negedge clk);
    sd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("wrst_busy_after", 32'(busy), 32'd0);
    check("wrst_acks", 32'(ack_cnt - a0), 32'd1);
    check("wrst_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtsdram_arb.md
JTSDRAM_ARB -- requirements
Module: jtsdram_arb

Interface
REQ-001 Parameter TOUT_W, default 10: width of the per-transaction timeout counter; the timeout limit is 2^TOUT_W-1 cycles.
REQ-002 The block SHALL provide the following ports.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- chN_rd  in  1  (N=0..3) read request from requester N
- chN_addr  in  22  word address from requester N
- chN_ack  out  1  one-cycle pulse: requester N's command accepted by SDRAM
- chN_rdy  out  1  one-cycle pulse: requester N's data valid on the shared data_read bus
- sd_rd  out  1  read request to SDRAM controller
- sd_addr  out  22  address to SDRAM controller
- sd_ba  out  2  bank index, equal to the granted channel number
- sd_ack  in  1  command accepted by SDRAM controller
- sd_rdy  in  1  read data valid from SDRAM controller
- refresh_req  in  1  refresh window request
- refresh_ok  out  1  high while the arbiter is idle and refresh_req is high
- busy  out  1  high in states REQ and WAIT
- timeout  out  1  sticky error flag

Function
REQ-003 The block SHALL implement the states IDLE, REQ and WAIT.
REQ-004 In IDLE with refresh_req low and at least one chN_rd high, the block SHALL pick a winner round-robin, searching from channel (last+1) mod 4, where last is the previous winner.
REQ-005 On that IDLE edge the block SHALL register grant=winner, sd_addr=chN_addr and sd_ba=winner, assert sd_rd, and enter REQ; sd_rd is therefore high on the first cycle after the request is sampled.
REQ-006 In IDLE with refresh_req high, the block SHALL issue no grant, even if a request arrives in the same cycle; refresh has priority.
REQ-007 refresh_ok SHALL be combinational: (state==IDLE) & refresh_req.
REQ-008 In REQ, the block SHALL hold sd_rd, sd_addr and sd_ba stable until sd_ack is sampled high.
REQ-009 On sd_ack in REQ, the block SHALL:
- deassert sd_rd on the next cycle;
- pulse ch[grant]_ack for exactly one cycle;
- enter WAIT.
REQ-010 If sd_ack and sd_rdy are high in the same cycle in REQ, the block SHALL pulse ch[grant]_ack and ch[grant]_rdy in the same cycle and return to IDLE.
REQ-011 In WAIT, on sd_rdy, the block SHALL pulse ch[grant]_rdy for one cycle, set last=grant, and return to IDLE.
REQ-012 The first new grant SHALL be possible on the cycle after the return to IDLE; back-to-back transactions need no extra idle cycle beyond the IDLE state itself.
REQ-013 The block SHALL keep all chN_ack/chN_rdy of non-granted channels at 0.
REQ-014 At most one ack and one rdy pulse SHALL be produced per transaction.
REQ-015 sd_ack or sd_rdy arriving in IDLE, and sd_rdy arriving in REQ without sd_ack, SHALL be ignored.
REQ-016 A requester dropping chN_rd after grant SHALL NOT abort the transaction; the transaction completes normally.
REQ-017 A TOUT_W-bit counter SHALL:
- clear on entry to REQ;
- increment each cycle in REQ/WAIT;
- saturate at its maximum value.
REQ-018 On reaching the maximum, the block SHALL set timeout (sticky until reset), deassert sd_rd, set last=grant, and return to IDLE without pulsing rdy.
REQ-019 busy SHALL equal (state!=IDLE).
REQ-020 Round-robin SHALL guarantee each continuously requesting channel a grant within 4 transactions.

Reset
REQ-021 While rst is high, the block SHALL:
- be in IDLE;
- hold grant=0, last=3 (so channel 0 has first priority), counter=0;
- hold sd_rd=0, sd_addr=0, sd_ba=0;
- hold all chN_ack/chN_rdy=0 and timeout=0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction immediately with no ack/rdy pulse; after release, a fresh arbitration starts.

Verification
REQ-023 Single request: ch2_rd=1, ch2_addr=22'h12345; sd_ack 3 cycles later, sd_rdy 5 cycles after ack -> sd_ba=2, sd_addr=22'h12345, one ch2_ack pulse, one ch2_rdy pulse, busy falls after rdy.
REQ-024 All four requesting continuously from reset -> grant order 0,1,2,3,0 across five transactions.
REQ-025 refresh_req=1 with ch1_rd=1 in IDLE -> refresh_ok=1 and sd_rd stays 0; refresh_req=0 -> ch1 granted the next cycle.
REQ-026 sd_ack and sd_rdy high in the same cycle -> ack and rdy pulse together on the granted channel; return to IDLE.
REQ-027 TOUT_W=4, sd_ack never asserted -> timeout=1 at cycle 15 of REQ, sd_rd=0, no rdy pulse; the next request is still served.
REQ-028 rst pulsed while in WAIT -> all outputs 0, state IDLE, no rdy pulse even if sd_rdy arrives afterward.
